// File: rtl/line_sensor_conditioner.sv
// line_sensor_conditioner: sync + debounce front end for the rover sensors.
// Emits clean levels, edge pulses, a cone latch and a line-lost timer.
module line_sensor_debounce #(
  parameter int WIDTH = 1,
  parameter int CYCLES = 16,
  parameter logic [WIDTH-1:0] INIT = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_next
);
  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic [CW-1:0]    cnt_step;
  logic [WIDTH-1:0] s_prev;

  // A new differing pattern restarts the run at 1
  always_comb begin
    cnt_step = (cnt == '0 || s != s_prev) ?
               CW'(1) : cnt + CW'(1);
    q_next   = q;
    cnt_next = '0;
    if (s != q) begin
      if (cnt_step == CW'(CYCLES)) q_next = s;
      else cnt_next = cnt_step;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q      <= INIT;
      cnt    <= '0;
      s_prev <= INIT;
    end else begin
      q      <= q_next;
      cnt    <= cnt_next;
      s_prev <= s;
    end
  end
endmodule

module line_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LOST_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] induct_raw,
  input  logic       proxim_raw,
  input  logic       red_raw,
  output logic [2:0] induct,
  output logic       proxim,
  output logic       red,
  output logic       red_rise,
  output logic       red_fall,
  output logic       proxim_rise,
  output logic       cone_flag,
  output logic       line_lost
);
  localparam int LW = $clog2(LOST_CYCLES + 1);
  localparam logic [4:0] IDLE = 5'b11100;

  logic [4:0]    sync1;
  logic [4:0]    sync2;
  logic [2:0]    induct_next;
  logic          proxim_next;
  logic          red_next;
  logic [LW-1:0] lcnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= IDLE;
      sync2 <= IDLE;
    end else begin
      sync1 <= {induct_raw, proxim_raw, red_raw};
      sync2 <= sync1;
    end
  end

  line_sensor_debounce #(
    .WIDTH(3), .CYCLES(DEBOUNCE_CYCLES), .INIT(3'b111)
  ) u_induct (
    .clk(clk), .reset_n(reset_n), .s(sync2[4:2]),
    .q(induct), .q_next(induct_next)
  );

  line_sensor_debounce #(
    .WIDTH(1), .CYCLES(DEBOUNCE_CYCLES), .INIT(1'b0)
  ) u_proxim (
    .clk(clk), .reset_n(reset_n), .s(sync2[1]),
    .q(proxim), .q_next(proxim_next)
  );

  line_sensor_debounce #(
    .WIDTH(1), .CYCLES(DEBOUNCE_CYCLES), .INIT(1'b0)
  ) u_red (
    .clk(clk), .reset_n(reset_n), .s(sync2[0]),
    .q(red), .q_next(red_next)
  );

  // Driven from next-level so pulses and counts line up with the levels
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      red_rise    <= 1'b0;
      red_fall    <= 1'b0;
      proxim_rise <= 1'b0;
      cone_flag   <= 1'b0;
      lcnt        <= '0;
    end else begin
      red_rise    <= red_next & ~red;
      red_fall    <= ~red_next & red;
      proxim_rise <= proxim_next & ~proxim;
      if (proxim_next & ~proxim) cone_flag <= 1'b1;
      else if (~red_next & red) cone_flag <= 1'b0;
      if (induct_next != 3'b111) lcnt <= '0;
      else if (lcnt != LW'(LOST_CYCLES)) lcnt <= lcnt + LW'(1);
    end
  end

  assign line_lost = (lcnt == LW'(LOST_CYCLES));
endmodule

// File: tb/tb_line_sensor_conditioner.sv
// Scoreboard bench for line_sensor_conditioner.
// Stimulus queues expected output vectors; a monitor compares per cycle.
module tb_line_sensor_conditioner;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] induct_raw = 3'b111;
  logic       proxim_raw = 1'b0;
  logic       red_raw = 1'b0;
  logic [2:0] induct;
  logic       proxim, red, red_rise, red_fall;
  logic       proxim_rise, cone_flag, line_lost;

  line_sensor_conditioner #(
    .DEBOUNCE_CYCLES(4), .LOST_CYCLES(10)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .induct_raw(induct_raw), .proxim_raw(proxim_raw),
    .red_raw(red_raw), .induct(induct), .proxim(proxim),
    .red(red), .red_rise(red_rise), .red_fall(red_fall),
    .proxim_rise(proxim_rise), .cone_flag(cone_flag),
    .line_lost(line_lost)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [9:0] v;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  exp_t end_e;
  int checks = 0;
  int errors = 0;

  logic [9:0] outv;
  assign outv = {induct, proxim, red, red_rise, red_fall,
                 proxim_rise, cone_flag, line_lost};

  // flags = {proxim, red, red_rise, red_fall, proxim_rise, cone, lost}
  function automatic void push(int at, logic [2:0] ind,
                               logic [6:0] flags, string name);
    exp_t e;
    e.at = at;
    e.v = {ind, flags};
    e.name = name;
    sb.push_back(e);
  endfunction

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic goto(int t);
    while (cyc < t) step(1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        mon_e = sb.pop_front();
        checks++;
        if (mon_e.at < cyc) begin
          errors++;
          $display("FAIL %s: cycle %0d passed unchecked",
                   mon_e.name, mon_e.at);
        end else if (outv !== mon_e.v) begin
          errors++;
          $display("FAIL %s @%0d: got %b expected %b",
                   mon_e.name, cyc, outv, mon_e.v);
        end
      end
    end
  end

  initial begin
    int t;
    int r;
    for (int i = 0; i < 5; i++) begin
      step(1);
      induct_raw = 3'(i);
      proxim_raw = i[0];
      red_raw = ~i[0];
      push(cyc, 3'b111, 7'b0000000, "rst_hold");
    end
    induct_raw = 3'b101;
    proxim_raw = 1'b0;
    red_raw = 1'b0;
    step(1);
    r = cyc;
    reset_n = 1'b1;
    push(r + 1, 3'b111, 7'b0000000, "rel1");
    push(r + 2, 3'b111, 7'b0000000, "rel2");
    push(r + 5, 3'b111, 7'b0000000, "ind_pre");
    push(r + 6, 3'b101, 7'b0000000, "ind_post");
    goto(r + 8);

    t = cyc;
    red_raw = 1'b1;
    for (int k = 1; k <= 10; k++)
      push(t + k, 3'b101, 7'b0000000, "glitch");
    step(3);
    red_raw = 1'b0;
    goto(t + 11);

    t = cyc;
    red_raw = 1'b1;
    push(t + 5, 3'b101, 7'b0000000, "red_pre");
    push(t + 6, 3'b101, 7'b0110000, "red_rise");
    push(t + 7, 3'b101, 7'b0100000, "red_hold");
    goto(t + 8);

    t = cyc;
    proxim_raw = 1'b1;
    push(t + 5, 3'b101, 7'b0100000, "px_pre");
    push(t + 6, 3'b101, 7'b1100110, "px_rise");
    push(t + 7, 3'b101, 7'b1100010, "cone_hold");
    step(5);
    proxim_raw = 1'b0;
    push(t + 10, 3'b101, 7'b1100010, "px_stay");
    push(t + 11, 3'b101, 7'b0100010, "px_fall");
    goto(t + 12);

    t = cyc;
    red_raw = 1'b0;
    push(t + 5, 3'b101, 7'b0100010, "rf_pre");
    push(t + 6, 3'b101, 7'b0001000, "red_fall");
    push(t + 7, 3'b101, 7'b0000000, "cone_clr");
    goto(t + 8);

    t = cyc;
    red_raw = 1'b1;
    push(t + 6, 3'b101, 7'b0110000, "red_rise2");
    goto(t + 8);

    t = cyc;
    red_raw = 1'b0;
    proxim_raw = 1'b1;
    push(t + 6, 3'b101, 7'b1001110, "set_wins");
    push(t + 7, 3'b101, 7'b1000010, "set_hold");
    step(7);
    proxim_raw = 1'b0;
    push(t + 13, 3'b101, 7'b0000010, "cone_keep");
    goto(t + 14);

    t = cyc;
    induct_raw = 3'b111;
    push(t + 5, 3'b101, 7'b0000010, "ind_pre111");
    push(t + 6, 3'b111, 7'b0000010, "ind111");
    push(t + 14, 3'b111, 7'b0000010, "lost9");
    push(t + 15, 3'b111, 7'b0000011, "lost10");
    goto(t + 17);

    t = cyc;
    induct_raw = 3'b011;
    for (int k = 3; k <= 7; k++)
      push(t + k, 3'b111, 7'b0000011, "no_011");
    push(t + 8, 3'b001, 7'b0000010, "ind001");
    step(2);
    induct_raw = 3'b001;
    goto(t + 10);

    t = cyc;
    induct_raw = 3'b111;
    push(t + 6, 3'b111, 7'b0000010, "ind111b");
    push(t + 14, 3'b111, 7'b0000010, "lost9b");
    push(t + 15, 3'b111, 7'b0000011, "lost10b");
    push(t + 16, 3'b101, 7'b0000010, "lost_drop");
    step(10);
    induct_raw = 3'b101;
    goto(t + 18);

    t = cyc;
    induct_raw = 3'b111;
    push(t + 15, 3'b111, 7'b0000011, "pre_rst");
    push(t + 16, 3'b111, 7'b0000000, "async_rst");
    goto(t + 16);
    #2;
    reset_n = 1'b0;
    induct_raw = 3'b110;
    red_raw = 1'b1;
    step(2);
    r = cyc;
    reset_n = 1'b1;
    push(r + 1, 3'b111, 7'b0000000, "post_rst1");
    push(r + 5, 3'b111, 7'b0000000, "post_rst5");
    push(r + 6, 3'b110, 7'b0110000, "post_rst6");
    goto(r + 8);

    step(2);
    while (sb.size() > 0) begin
      end_e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: cycle %0d never compared",
               end_e.name, end_e.at);
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
